// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer/flag controller of the dual-clock FIFO (read clock domain).
// Synchronises the write Gray pointer and produces empty, fill level, read strobes.
module fifo_rd_ctrl #(
  parameter int W_ADDR = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pop,
  input  logic [W_ADDR:0]   wr_ptr_gray_async,
  output logic              re,
  output logic [W_ADDR-1:0] rd_addr,
  output logic              rd_valid,
  output logic [W_ADDR:0]   rd_ptr_gray,
  output logic              empty,
  output logic [W_ADDR:0]   rd_level,
  output logic              underflow
);

  logic [W_ADDR:0] rd_ptr_bin_r;
  logic [W_ADDR:0] wq1_r;
  logic [W_ADDR:0] wq2_r;
  logic            accept_s;
  logic [W_ADDR:0] bin_next_s;
  logic [W_ADDR:0] gray_next_s;
  logic [W_ADDR:0] wr_bin_s;

  function automatic logic [W_ADDR:0] gray2bin(input logic [W_ADDR:0] g);
    logic [W_ADDR:0] b;
    b[W_ADDR] = g[W_ADDR];
    for (int i = W_ADDR - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Accept, next-pointer and synchronised write-pointer decode
  always_comb begin
    accept_s    = pop & ~empty & ~rst;
    bin_next_s  = rd_ptr_bin_r + {{W_ADDR{1'b0}}, accept_s};
    gray_next_s = bin_next_s ^ (bin_next_s >> 1);
    wr_bin_s    = gray2bin(wq2_r);
  end

  assign re      = accept_s;
  assign rd_addr = rd_ptr_bin_r[W_ADDR-1:0];

  // Pointers, synchroniser and flags; flags compare the next read pointer
  // against the already-synchronised write pointer, so they never lead a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_bin_r <= '0;
      rd_ptr_gray  <= '0;
      wq1_r        <= '0;
      wq2_r        <= '0;
      empty        <= 1'b1;
      rd_level     <= '0;
      rd_valid     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      rd_ptr_bin_r <= bin_next_s;
      rd_ptr_gray  <= gray_next_s;
      wq1_r        <= wr_ptr_gray_async;
      wq2_r        <= wq1_r;
      empty        <= (gray_next_s == wq2_r);
      rd_level     <= wr_bin_s - bin_next_s;
      rd_valid     <= accept_s;
      underflow    <= pop & empty;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed vector table, wrap sequence,
// and randomized traffic against a count-based reference model.
module tb_fifo_rd_ctrl;
  localparam int W_ADDR = 4;
  localparam int PW = W_ADDR + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              pop;
  logic [PW-1:0]     wr_ptr_gray_async;
  logic              re;
  logic [W_ADDR-1:0] rd_addr;
  logic              rd_valid;
  logic [PW-1:0]     rd_ptr_gray;
  logic              empty;
  logic [PW-1:0]     rd_level;
  logic              underflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_rd_ctrl #(.W_ADDR(W_ADDR)) dut (
    .clk(clk), .rst(rst), .pop(pop), .wr_ptr_gray_async(wr_ptr_gray_async),
    .re(re), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ptr_gray(rd_ptr_gray),
    .empty(empty), .rd_level(rd_level), .underflow(underflow)
  );

  typedef struct {
    logic r;
    logic p;
    int   w;
    logic e_re;
    int   e_addr;
    logic e_valid;
    int   e_gray;
    logic e_empty;
    int   e_level;
    logic e_uf;
  } vec_t;

  vec_t tab [21];

  // reference model: plain counts of words written (as seen after sync) and read
  int m_rd = 0, m_w1 = 0, m_w2 = 0, m_level = 0;
  logic m_empty = 1'b1, m_valid = 1'b0, m_uf = 1'b0;

  logic capture = 1'b0;
  int   addr_q [$];

  function automatic logic [PW-1:0] to_gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int mod32(input int x);
    return ((x % 32) + 32) % 32;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic p, input int w);
    logic acc;
    if (r) begin
      m_rd = 0; m_w1 = 0; m_w2 = 0; m_empty = 1'b1; m_level = 0;
      m_valid = 1'b0; m_uf = 1'b0;
    end else begin
      acc     = p && !m_empty;
      m_uf    = p && m_empty;
      m_rd    = m_rd + (acc ? 1 : 0);
      m_empty = (m_w2 == m_rd);
      m_level = m_w2 - m_rd;
      m_valid = acc;
      m_w2    = m_w1;
      m_w1    = w;
    end
  endtask

  task automatic drive(input logic r, input logic p, input int w);
    @(negedge clk);
    rst = r;
    pop = p;
    wr_ptr_gray_async = to_gray(w);
    #1;
  endtask

  task automatic step_tab(input int i);
    drive(tab[i].r, tab[i].p, tab[i].w);
    chk($sformatf("re[%0d]", i), 32'(re), 32'(tab[i].e_re));
    chk($sformatf("rd_addr[%0d]", i), 32'(rd_addr), tab[i].e_addr);
    @(posedge clk);
    model_update(tab[i].r, tab[i].p, tab[i].w);
    #1;
    chk($sformatf("rd_valid[%0d]", i), 32'(rd_valid), 32'(tab[i].e_valid));
    chk($sformatf("rd_ptr_gray[%0d]", i), 32'(rd_ptr_gray), tab[i].e_gray);
    chk($sformatf("empty[%0d]", i), 32'(empty), 32'(tab[i].e_empty));
    chk($sformatf("rd_level[%0d]", i), 32'(rd_level), tab[i].e_level);
    chk($sformatf("underflow[%0d]", i), 32'(underflow), 32'(tab[i].e_uf));
  endtask

  task automatic step_m(input logic r, input logic p, input int w);
    drive(r, p, w);
    chk("m_re", 32'(re), 32'(!r && p && !m_empty));
    chk("m_rd_addr", 32'(rd_addr), m_rd % 16);
    if (capture && re) addr_q.push_back(int'(rd_addr));
    @(posedge clk);
    model_update(r, p, w);
    #1;
    chk("m_rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("m_rd_ptr_gray", 32'(rd_ptr_gray), 32'(to_gray(m_rd)));
    chk("m_empty", 32'(empty), 32'(m_empty));
    chk("m_rd_level", 32'(rd_level), mod32(m_level));
    chk("m_underflow", 32'(underflow), 32'(m_uf));
  endtask

  initial begin
    int w;
    logic [PW-1:0] prev_gray;
    rst = 1'b1;
    pop = 1'b0;
    wr_ptr_gray_async = '0;

    //            r     p     w   re    addr val   gray emp   lvl uf
    tab[0]  = '{1'b1, 1'b1, 0,  1'b0, 0, 1'b0, 0, 1'b1, 0,  1'b0};
    tab[1]  = '{1'b1, 1'b1, 0,  1'b0, 0, 1'b0, 0, 1'b1, 0,  1'b0};
    tab[2]  = '{1'b1, 1'b1, 0,  1'b0, 0, 1'b0, 0, 1'b1, 0,  1'b0};
    tab[3]  = '{1'b0, 1'b0, 1,  1'b0, 0, 1'b0, 0, 1'b1, 0,  1'b0};
    tab[4]  = '{1'b0, 1'b0, 1,  1'b0, 0, 1'b0, 0, 1'b1, 0,  1'b0};
    tab[5]  = '{1'b0, 1'b0, 1,  1'b0, 0, 1'b0, 0, 1'b0, 1,  1'b0};
    tab[6]  = '{1'b0, 1'b0, 2,  1'b0, 0, 1'b0, 0, 1'b0, 1,  1'b0};
    tab[7]  = '{1'b0, 1'b0, 2,  1'b0, 0, 1'b0, 0, 1'b0, 1,  1'b0};
    tab[8]  = '{1'b0, 1'b0, 2,  1'b0, 0, 1'b0, 0, 1'b0, 2,  1'b0};
    tab[9]  = '{1'b0, 1'b1, 2,  1'b1, 0, 1'b1, 1, 1'b0, 1,  1'b0};
    tab[10] = '{1'b0, 1'b1, 2,  1'b1, 1, 1'b1, 3, 1'b1, 0,  1'b0};
    tab[11] = '{1'b0, 1'b1, 2,  1'b0, 2, 1'b0, 3, 1'b1, 0,  1'b1};
    tab[12] = '{1'b0, 1'b0, 2,  1'b0, 2, 1'b0, 3, 1'b1, 0,  1'b0};
    tab[13] = '{1'b0, 1'b0, 18, 1'b0, 2, 1'b0, 3, 1'b1, 0,  1'b0};
    tab[14] = '{1'b0, 1'b0, 18, 1'b0, 2, 1'b0, 3, 1'b1, 0,  1'b0};
    tab[15] = '{1'b0, 1'b0, 18, 1'b0, 2, 1'b0, 3, 1'b0, 16, 1'b0};
    tab[16] = '{1'b0, 1'b1, 18, 1'b1, 2, 1'b1, 2, 1'b0, 15, 1'b0};
    tab[17] = '{1'b0, 1'b1, 18, 1'b1, 3, 1'b1, 6, 1'b0, 14, 1'b0};
    tab[18] = '{1'b0, 1'b1, 18, 1'b1, 4, 1'b1, 7, 1'b0, 13, 1'b0};
    tab[19] = '{1'b1, 1'b1, 18, 1'b0, 5, 1'b0, 0, 1'b1, 0,  1'b0};
    tab[20] = '{1'b1, 1'b0, 0,  1'b0, 0, 1'b0, 0, 1'b1, 0,  1'b0};

    for (int i = 0; i < 21; i++) step_tab(i);

    // wrap: 40 writes, continuous pops, address sequence and Gray single-bit steps
    w = 0;
    capture = 1'b1;
    prev_gray = rd_ptr_gray;
    for (int c = 0; c < 60; c++) begin
      if (w < 40 && (w + 1 - m_rd) <= 16) w++;
      step_m(1'b0, 1'b1, w);
      chk("gray_one_bit_step", 32'($countones(rd_ptr_gray ^ prev_gray) <= 1), 32'd1);
      prev_gray = rd_ptr_gray;
    end
    capture = 1'b0;
    chk("wrap_pop_count", addr_q.size(), 40);
    for (int i = 0; i < addr_q.size() && i < 40; i++)
      chk($sformatf("wrap_addr[%0d]", i), addr_q[i], i % 16);
    chk("wrap_final_empty", 32'(empty), 32'd1);
    chk("wrap_final_level", 32'(rd_level), 32'd0);

    // randomized traffic with occasional resets
    step_m(1'b1, 1'b0, 0);
    w = 0;
    for (int c = 0; c < 600; c++) begin
      logic r;
      logic p;
      int adv;
      r = ($urandom_range(0, 49) == 0);
      p = ($urandom_range(0, 9) < 7);
      if (r) begin
        w = 0;
      end else begin
        adv = $urandom_range(0, 3);
        if (w + adv - m_rd > 16) adv = m_rd + 16 - w;
        if (adv < 0) adv = 0;
        w = w + adv;
      end
      step_m(r, p, w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
